// File: rtl/input_ram_reader.sv
// rtl/input_ram_reader.sv - drains one input packet RAM in address order onto a valid/ready stream
module input_ram_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int SKID_D = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [ADDR_W-1:0] wr_add,
    output logic [ADDR_W-1:0] ram_rd_add,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              empty
);

    localparam int IW = (SKID_D > 1) ? $clog2(SKID_D) : 1;
    localparam int CW = $clog2(SKID_D + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SKID_D - 1);
    localparam logic [CW:0]   DEPTH    = (CW+1)'(SKID_D);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic              in_flight;
    logic [DATA_W-1:0] skid_mem [SKID_D];
    logic [IW-1:0]     head;
    logic [IW-1:0]     tail;
    logic [CW-1:0]     count;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CW:0]       occ_after_pop;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // Stream is presented straight from the buffer head so it stays stable under backpressure
    assign out_valid = (count != '0);
    assign out_data  = skid_mem[head];
    assign pop       = out_valid && out_ready;
    assign push      = in_flight;

    // Occupancy after this cycle's pop; a read is only issued if its word is guaranteed a slot
    assign occ_after_pop = {1'b0, count} + (CW+1)'(in_flight) - (CW+1)'(pop);

    // Reads are gated by enable directly so the first word reaches the stream two cycles after enable
    assign issue      = enable && (state != FLUSH) && !clear && (rd_ptr != wr_add)
                        && (occ_after_pop < DEPTH);
    assign ram_rden   = issue;
    assign ram_rd_add = rd_ptr;
    assign empty      = (rd_ptr == wr_add) && !in_flight && (count == '0);

    // Control FSM: clear forces a single FLUSH cycle, enable toggles IDLE/RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (clear) begin
            state <= FLUSH;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= IDLE;
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read pointer and in-flight marker; clearing drops the outstanding RAM word
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr    <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Skid buffer: captures RAM data the cycle after a read, releases on handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < SKID_D; i++) skid_mem[i] <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                skid_mem[tail] <= ram_q;
                tail           <= idx_inc(tail);
            end
            if (pop) head <= idx_inc(head);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_input_ram_reader.sv
// tb/tb_input_ram_reader.sv - directed self-checking bench for input_ram_reader
module tb_input_ram_reader;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          clear;
    logic          out_ready;
    logic [AW-1:0] wr_add;
    logic [AW-1:0] ram_rd_add;
    logic [AW-1:0] rd_ptr;
    logic          ram_rden;
    logic          out_valid;
    logic          empty;
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] out_data;
    logic [DW-1:0] ram [4096];

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    input_ram_reader #(.DATA_W(DW), .ADDR_W(AW), .SKID_D(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .wr_add     (wr_add),
        .ram_rd_add (ram_rd_add),
        .ram_rden   (ram_rden),
        .ram_q      (ram_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd_ptr     (rd_ptr),
        .empty      (empty)
    );

    // 1-cycle-latency RAM model
    always @(posedge clk) if (ram_rden) ram_q <= ram[ram_rd_add];

    function automatic logic [31:0] word(input int a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    task automatic exp_cyc(input string tag, input bit er, input int ea, input bit ev, input logic [31:0] ed);
        check({tag, ".rden"}, 64'(ram_rden), 64'(er));
        if (er) check({tag, ".radd"}, 64'(ram_rd_add), 64'(ea % 4096));
        check({tag, ".valid"}, 64'(out_valid), 64'(ev));
        if (ev) check({tag, ".data"}, 64'(out_data), 64'(ed));
    endtask

    task automatic restart();
        reset = 1'b1; enable = 1'b0; clear = 1'b0; wr_add = '0; out_ready = 1'b1;
        next();
        reset = 1'b0; enable = 1'b1;
        next();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; wr_add = '0; out_ready = 1'b0;
        for (int i = 0; i < 4096; i++) ram[i] = word(i);
        next();
        next();
        reset = 1'b0;
        look();
        check("rst.rden", 64'(ram_rden), 64'(0));
        check("rst.valid", 64'(out_valid), 64'(0));
        check("rst.data", 64'(out_data), 64'(0));
        check("rst.rd_ptr", 64'(rd_ptr), 64'(0));
        check("rst.empty", 64'(empty), 64'(1));

        // nothing written: enable must not cause reads
        enable = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            look();
            exp_cyc("t1", 1'b0, 0, 1'b0, 32'h0);
            next();
        end
        look();
        check("t1.empty", 64'(empty), 64'(1));
        check("t1.rd_ptr", 64'(rd_ptr), 64'(0));

        // four words, ready held high: back-to-back stream
        restart();
        wr_add = 12'd4;
        for (int c = 0; c < 7; c++) begin
            look();
            exp_cyc("t2", c < 4, c, (c >= 2) && (c <= 5), word(c - 2));
            if (c == 6) begin
                check("t2.rd_ptr", 64'(rd_ptr), 64'(4));
                check("t2.empty", 64'(empty), 64'(1));
            end
            next();
        end

        // backpressure cycles 2..6: only two reads, A0 held, then in-order drain
        restart();
        wr_add = 12'd4;
        for (int c = 0; c < 12; c++) begin
            out_ready = !((c >= 2) && (c <= 6));
            look();
            exp_cyc("t3", (c == 0) || (c == 1) || (c == 7) || (c == 8),
                    (c < 2) ? c : c - 5,
                    (c >= 2) && (c <= 10),
                    word((c <= 7) ? 0 : c - 7));
            if (c == 6) check("t3.rd_ptr", 64'(rd_ptr), 64'(2));
            if (c == 11) check("t3.empty", 64'(empty), 64'(1));
            next();
        end

        // pointer wrap: drain to 4094, then writer wraps to 2
        restart();
        out_ready = 1'b1;
        wr_add = 12'd4094;
        n = 0;
        while (!((rd_ptr == 12'd4094) && empty) && (n < 6000)) begin
            next();
            n++;
        end
        check("t4.drain_reached", 64'(n < 6000), 64'(1));
        wr_add = 12'd2;
        for (int c = 0; c < 7; c++) begin
            look();
            exp_cyc("t4", c < 4, 4094 + c, (c >= 2) && (c <= 5), word((4094 + c - 2) % 4096));
            if (c == 6) begin
                check("t4.rd_ptr", 64'(rd_ptr), 64'(2));
                check("t4.empty", 64'(empty), 64'(1));
            end
            next();
        end

        // clear with a word buffered and one in flight
        restart();
        wr_add = 12'd4; out_ready = 1'b0;
        look();
        exp_cyc("t5.c0", 1'b1, 0, 1'b0, 32'h0);
        next();
        look();
        exp_cyc("t5.c1", 1'b1, 1, 1'b0, 32'h0);
        next();
        clear = 1'b1;
        look();
        exp_cyc("t5.c2", 1'b0, 0, 1'b1, word(0));
        next();
        clear = 1'b0; wr_add = 12'd2; out_ready = 1'b1;
        look();
        exp_cyc("t5.flush", 1'b0, 0, 1'b0, 32'h0);
        check("t5.rd_ptr0", 64'(rd_ptr), 64'(0));
        next();
        for (int c = 4; c < 9; c++) begin
            look();
            exp_cyc("t5", (c == 4) || (c == 5), c - 4, (c == 6) || (c == 7), word(c - 6));
            if (c == 8) begin
                check("t5.rd_ptr", 64'(rd_ptr), 64'(2));
                check("t5.empty", 64'(empty), 64'(1));
            end
            next();
        end

        // enable dropped after two reads, then resumed
        restart();
        wr_add = 12'd4; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            enable = (c < 2);
            look();
            exp_cyc("t6a", c < 2, c, (c == 2) || (c == 3), word(c - 2));
            if (c == 5) begin
                check("t6a.rd_ptr", 64'(rd_ptr), 64'(2));
                check("t6a.empty", 64'(empty), 64'(0));
            end
            next();
        end
        enable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            look();
            exp_cyc("t6b", c < 2, c + 2, (c == 2) || (c == 3), word(c));
            if (c == 4) begin
                check("t6b.rd_ptr", 64'(rd_ptr), 64'(4));
                check("t6b.empty", 64'(empty), 64'(1));
            end
            next();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
